// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl: lock supervisor and run-time phase-step sequencer for a MAX10 PLL.
// Pulses areset, qualifies lock, then steps one output counter's phase per host request.
module pll_phase_ctrl #(
  parameter int NCLK          = 2,
  parameter int ARESET_CYCLES = 16,
  parameter int LOCK_WAIT     = 1024,
  parameter int TIMEOUT       = 255,
  parameter int PW            = 8
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_pll_locked,
  input  logic               i_pll_phasedone,
  output logic               o_pll_areset,
  output logic               o_pll_phasestep,
  output logic               o_pll_phaseupdown,
  output logic [2:0]         o_pll_cntsel,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [2:0]         i_req_chan,
  input  logic               i_req_dir,
  input  logic [7:0]         i_req_steps,
  output logic               o_ready,
  output logic               o_busy,
  output logic               o_err,
  output logic               o_lost,
  output logic [NCLK*PW-1:0] o_phase
);

  localparam int CMAX0 = (ARESET_CYCLES > LOCK_WAIT) ? ARESET_CYCLES : LOCK_WAIT;
  localparam int CMAX  = (CMAX0 > TIMEOUT) ? CMAX0 : TIMEOUT;
  localparam int CW    = $clog2(CMAX + 1);
  localparam logic [CW-1:0] AR_LAST   = CW'(ARESET_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_WAIT);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [3:0]    NCLK_W    = 4'(NCLK);
  localparam logic [PW-1:0] PMAX      = {1'b0, {(PW-1){1'b1}}};
  localparam logic [PW-1:0] PMIN      = {1'b1, {(PW-1){1'b0}}};
  localparam logic [PW-1:0] PONE      = PW'(1);

  typedef enum logic [2:0] {
    S_AR, S_WLOCK, S_IDLE, S_SETUP, S_STEP, S_WLOW, S_WHIGH
  } state_t;

  state_t             r_state, w_nextState;
  logic [CW-1:0]      r_cnt, w_nextCnt;
  logic [2:0]         r_chan, w_nextChan;
  logic               r_dir, w_nextDir;
  logic [7:0]         r_steps, w_nextSteps;
  logic [NCLK*PW-1:0] r_phase, w_nextPhase;
  logic               r_err, w_nextErr;
  logic               r_lost, w_nextLost;
  logic               r_areset, r_phasestep, r_updown, r_reqReady, r_ready, r_busy;
  logic [2:0]         r_cntsel;
  logic [PW-1:0]      w_cur, w_upd;
  logic               w_active, w_seq, w_live;

  assign w_active = r_state inside {S_IDLE, S_SETUP, S_STEP, S_WLOW, S_WHIGH};
  assign w_seq    = w_nextState inside {S_SETUP, S_STEP, S_WLOW, S_WHIGH};
  assign w_live   = w_seq || (w_nextState == S_IDLE);

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextChan  = r_chan;
    w_nextDir   = r_dir;
    w_nextSteps = r_steps;
    w_nextPhase = r_phase;
    w_nextErr   = r_err;
    w_nextLost  = r_lost;
    w_cur       = '0;
    for (int k = 0; k < NCLK; k++) begin
      if (r_chan == 3'(k)) w_cur = r_phase[k*PW +: PW];
    end
    // Saturating +/-1 on the selected channel's signed count
    w_upd = w_cur;
    if (r_dir && (w_cur != PMAX)) w_upd = w_cur + PONE;
    else if (!r_dir && (w_cur != PMIN)) w_upd = w_cur - PONE;

    if (w_active && !i_pll_locked) begin
      w_nextState = S_AR;
      w_nextCnt   = '0;
      w_nextLost  = 1'b1;
    end else begin
      case (r_state)
        S_AR: begin
          if (r_cnt == AR_LAST) begin
            w_nextState = S_WLOCK;
            w_nextCnt   = '0;
          end else begin
            w_nextCnt = r_cnt + CNT_ONE;
          end
        end
        S_WLOCK: begin
          if (!i_pll_locked) begin
            w_nextCnt = '0;
          end else if (r_cnt == LOCK_LAST) begin
            w_nextState = S_IDLE;
            w_nextCnt   = '0;
          end else begin
            w_nextCnt = r_cnt + CNT_ONE;
          end
        end
        S_IDLE: begin
          if (i_req_valid) begin
            if ({1'b0, i_req_chan} >= NCLK_W) begin
              w_nextErr = 1'b1;
            end else begin
              w_nextErr = 1'b0;
              if (i_req_steps != 8'd0) begin
                w_nextState = S_SETUP;
                w_nextChan  = i_req_chan;
                w_nextDir   = i_req_dir;
                w_nextSteps = i_req_steps;
              end
            end
          end
        end
        S_SETUP: begin
          w_nextState = S_STEP;
          w_nextCnt   = '0;
        end
        S_STEP: begin
          if (r_cnt == CNT_ONE) begin
            w_nextState = S_WLOW;
            w_nextCnt   = '0;
          end else begin
            w_nextCnt = r_cnt + CNT_ONE;
          end
        end
        S_WLOW: begin
          w_nextCnt = r_cnt + CNT_ONE;
          if (!i_pll_phasedone) begin
            w_nextState = S_WHIGH;
          end else if (r_cnt >= TO_LAST) begin
            w_nextState = S_AR;
            w_nextCnt   = '0;
            w_nextErr   = 1'b1;
          end
        end
        S_WHIGH: begin
          w_nextCnt = r_cnt + CNT_ONE;
          if (i_pll_phasedone) begin
            for (int k = 0; k < NCLK; k++) begin
              if (r_chan == 3'(k)) w_nextPhase[k*PW +: PW] = w_upd;
            end
            w_nextSteps = r_steps - 8'd1;
            w_nextCnt   = '0;
            w_nextState = (r_steps == 8'd1) ? S_IDLE : S_SETUP;
          end else if (r_cnt >= TO_LAST) begin
            w_nextState = S_AR;
            w_nextCnt   = '0;
            w_nextErr   = 1'b1;
          end
        end
        default: begin
          w_nextState = S_AR;
          w_nextCnt   = '0;
        end
      endcase
    end

    // A PLL reset restores the compiled phases, so the accumulators follow it
    if (w_nextState == S_AR) w_nextPhase = '0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_AR;
      r_cnt       <= '0;
      r_chan      <= 3'd0;
      r_dir       <= 1'b0;
      r_steps     <= 8'd0;
      r_phase     <= '0;
      r_err       <= 1'b0;
      r_lost      <= 1'b0;
      r_areset    <= 1'b1;
      r_phasestep <= 1'b0;
      r_updown    <= 1'b0;
      r_cntsel    <= 3'd0;
      r_reqReady  <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_cnt       <= w_nextCnt;
      r_chan      <= w_nextChan;
      r_dir       <= w_nextDir;
      r_steps     <= w_nextSteps;
      r_phase     <= w_nextPhase;
      r_err       <= w_nextErr;
      r_lost      <= w_nextLost;
      r_areset    <= (w_nextState == S_AR);
      r_phasestep <= (w_nextState == S_STEP);
      r_updown    <= w_seq & w_nextDir;
      r_cntsel    <= w_seq ? (w_nextChan + 3'd2) : 3'd0;
      r_reqReady  <= (w_nextState == S_IDLE);
      r_ready     <= w_live;
      r_busy      <= w_seq;
    end
  end

  assign o_pll_areset      = r_areset;
  assign o_pll_phasestep   = r_phasestep;
  assign o_pll_phaseupdown = r_updown;
  assign o_pll_cntsel      = r_cntsel;
  assign o_req_ready       = r_reqReady;
  assign o_ready           = r_ready;
  assign o_busy            = r_busy;
  assign o_err             = r_err;
  assign o_lost            = r_lost;
  assign o_phase           = r_phase;

endmodule

// File: doc/pll_phase_ctrl.md
# pll_phase_ctrl

Parametrised lock-supervision and dynamic phase-shift controller for a MAX10 `fiftyfivenm_pll`. It sits beside the PLL wrapper. It drives the PLL `areset` and waits for a stable lock before declaring the clocks ready. It then accepts host requests to step the phase of any of NCLK output counters. Its main use is trimming the SDRAM clock phase at run time instead of recompiling.

## Interface

Parameters:
- NCLK, 2: number of PLL output counters controllable, 1..5.
- ARESET_CYCLES, 16: cycles `o_pll_areset` is held high per reset pulse, >=2.
- LOCK_WAIT, 1024: consecutive locked cycles required before `o_ready`.
- TIMEOUT, 255: maximum cycles to wait for `phasedone` per step.
- PW, 8: width of the per-channel signed phase accumulator.

Ports:
- i_clk, in, 1: sole clock; also drives PLL `scanclk`.
- i_reset_n, in, 1: reset, asynchronous and active-low.
- i_pll_locked, in, 1: PLL `locked`, pre-synchronised by the caller.
- i_pll_phasedone, in, 1: PLL `phasedone`.
- o_pll_areset, out, 1: PLL `areset`.
- o_pll_phasestep, out, 1: PLL `phasestep`.
- o_pll_phaseupdown, out, 1: PLL `phaseupdown`, 1 = advance.
- o_pll_cntsel, out, 3: PLL `phasecounterselect`.
- i_req_valid, in, 1: phase-step request valid.
- o_req_ready, out, 1: request accepted when high together with valid.
- i_req_chan, in, 3: output counter index, 0..NCLK-1.
- i_req_dir, in, 1: 1 = up, 0 = down.
- i_req_steps, in, 8: number of steps, 0 = no-op.
- o_ready, out, 1: PLL locked and stable, clocks usable.
- o_busy, out, 1: a step sequence is in progress.
- o_err, out, 1: sticky; set by a bad channel or a timeout; cleared by the next accepted valid request.
- o_lost, out, 1: sticky; set on loss of lock after ready; cleared only by reset.
- o_phase, out, NCLK*PW: per-channel signed net step count; channel k occupies bits [k*PW +: PW].

## Operation

- States: AR, WLOCK, IDLE, SETUP, STEP, WLOW, WHIGH.
- AR: `o_pll_areset`=1 for ARESET_CYCLES cycles, then go to WLOCK. All of `o_phase` is cleared, because a PLL reset restores the compiled phases.
- WLOCK: a counter increments while `i_pll_locked`=1 and clears to 0 when it drops. At LOCK_WAIT the block goes to IDLE and sets `o_ready`=1.
- IDLE: `o_req_ready`=1.
  - On an accepted request with `i_req_chan`>=NCLK: set `o_err` and stay in IDLE.
  - On an accepted request with steps=0: stay in IDLE; `o_err` is cleared.
  - Otherwise latch chan, dir and steps, clear `o_err`, and go to SETUP.
- SETUP (1 cycle): drive `o_pll_cntsel`=chan+2 (C0=010) and `o_pll_phaseupdown`=dir.
- STEP (2 cycles): `o_pll_phasestep`=1.
- WLOW: wait for `i_pll_phasedone`=0, then go to WHIGH.
- WHIGH: wait for `i_pll_phasedone`=1, then:
  - update `o_phase[chan]` by ±1, saturating at the signed PW limits;
  - decrement remaining steps;
  - if remaining steps are zero, go to IDLE, otherwise go to SETUP.
- Timeout: a timeout counter runs across WLOW plus WHIGH and clears on entry to WLOW. On reaching TIMEOUT: set `o_err`, abort the request, go to AR, and drop `o_ready` to 0.
- Lock loss: `i_pll_locked`=0 in any state from IDLE through WHIGH sets `o_lost`, drops `o_ready`, and goes to AR. This has priority over every other transition in the same cycle.
- cntsel and updown stay held through STEP, WLOW and WHIGH. Outside a sequence they are 000 and 0.
- `o_busy`=1 in SETUP through WHIGH.

## Timing

- Reset values: o_pll_areset=1, o_pll_phasestep=0, o_pll_phaseupdown=0, o_pll_cntsel=000, o_req_ready=0, o_ready=0, o_busy=0, o_err=0, o_lost=0, o_phase=0. The state is AR with its counter at 0.
- All outputs are registered. A reset release mid-sequence starts again from AR.
- `o_ready` rises ARESET_CYCLES + LOCK_WAIT + 1 cycles after reset release, given a continuous lock.
- Acceptance happens in the cycle where valid and ready are both high. `o_req_ready` drops in the following cycle.
- One step takes 1 + 2 + (cycles to phasedone low) + (cycles to phasedone high) cycles. With phasedone responding in 1 cycle each, a step takes 5 cycles.
- Each `o_phase` update is visible in the cycle after phasedone is sampled high.
- `o_req_ready` returns high in that same cycle after the final step.

## Test plan

- Reset then lock: release reset; `i_pll_locked` rises at cycle 20 and stays high (defaults) -> `o_pll_areset` falls after 16 cycles; `o_ready`=1 exactly 1024 lock cycles later; `o_phase`=0.
- Lock glitch in WLOCK: locked goes low for 1 cycle at count 500 -> counter restarts; `o_ready` is delayed by 501 cycles.
- Step: chan=1, dir=1, steps=3, phasedone model responding in 1 cycle -> three 2-cycle `phasestep` pulses with cntsel=011 and updown=1; `o_phase[1]`=+3; busy for 15 cycles.
- Saturation plus down-step: PW=4, 10 up-steps on chan 0 then 2 down-steps -> `o_phase[0]` reaches 7 (saturated), then reads 5.
- Errors: chan=5 with NCLK=2 -> `o_err`=1, no `phasestep` pulse. Then phasedone stuck high during a step -> after 255 cycles `o_err`=1, `o_ready`=0, `o_pll_areset` pulses and the block re-locks.
- Lock loss mid-step: locked goes low during WHIGH -> `o_lost`=1, state AR, `o_phase` cleared, `o_lost` stays set after re-lock.
